// File: rtl/cdb_arbiter.sv
// Common data bus transmit arbiter: buffers results per functional unit and broadcasts one per cycle.
// Latency: a result accepted at edge E appears on cdb_out after edge E+1 (no bypass), 1/cycle sustained.
// Backpressure: fu_ready[i] drops when unit i's buffer is full (decoded from registered count only).
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   flush            synchronous discard of every buffered and pending result
//   fu_valid/ready   per-unit result handshake, unit index equals funct_unit_t
//   fu_result        per-unit cdb_t, unit i at [i*$bits(cdb_t) +: $bits(cdb_t)], .valid ignored
//   cdb_out          registered broadcast, cdb_out.valid qualifies the other fields
//   grant_id         unit that sourced cdb_out, 0 when nothing is broadcast
//   stall_cnt        (CDB_STALL_CNT_EN only) 8-bit saturating stall counter per unit
//
// Optional feature macro: CDB_STALL_CNT_EN

typedef enum logic [1:0] {
    ARITH_UNIT   = 2'd0,
    MEM_UNIT     = 2'd1,
    BR_UNIT      = 2'd2,
    MUL_DIV_UNIT = 2'd3
} funct_unit_t;

typedef enum logic {
    INVALID = 1'b0,
    VALID   = 1'b1
} cdb_valid_t;

typedef struct packed {
    cdb_valid_t  valid;
    logic [6:0]  rd_paddr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [4:0]  rob_addr;
    logic        br_result;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
} cdb_t;

module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_FU-1:0]              fu_valid,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic [NUM_FU*$bits(cdb_t)-1:0] fu_result,
    output cdb_t                           cdb_out,
    output logic [1:0]                     grant_id
`ifdef CDB_STALL_CNT_EN
    ,
    output logic [8*NUM_FU-1:0]            stall_cnt
`endif
);

    localparam int CDB_W = $bits(cdb_t);
    // A depth-1 buffer still gets a 1-bit pointer; ptr_next pins it at 0.
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    cdb_t              buf_mem [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0]  head    [NUM_FU];
    logic [PTR_W-1:0]  tail    [NUM_FU];
    logic [CNT_W-1:0]  count   [NUM_FU];
    logic [1:0]        rr_ptr;

    logic [NUM_FU-1:0] not_empty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic              any_grant;
    logic [1:0]        win;
    logic [1:0]        scan;
    logic [1:0]        rr_next;
    cdb_t              grant_entry;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Ready depends only on the registered count, so a full buffer stays
    // not-ready even in a cycle where it is about to be popped.
    always_comb begin
        not_empty = '0;
        fu_ready  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            not_empty[i] = (count[i] != '0);
            fu_ready[i]  = !rst && (count[i] != FULL_CNT);
        end
    end

    assign push = fu_valid & fu_ready;

    // Round-robin search starting at rr_ptr, wrapping past NUM_FU-1 to 0.
    always_comb begin
        any_grant = 1'b0;
        win       = '0;
        scan      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan = 2'((int'(rr_ptr) + k) % NUM_FU);
            if (!any_grant && not_empty[scan]) begin
                any_grant = 1'b1;
                win       = scan;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (any_grant) begin
            pop[win] = 1'b1;
        end
        rr_next = (int'(win) == NUM_FU - 1) ? 2'd0 : win + 2'd1;
        grant_entry       = buf_mem[win][head[win]];
        grant_entry.valid = VALID;
    end

    // Payload storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i] && !flush) begin
                buf_mem[i][tail[i]] <= fu_result[i*CDB_W +: CDB_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr   <= '0;
            cdb_out  <= '0;
            grant_id <= '0;
        end else if (flush) begin
            // Flush wins over both accept and pop; payload fields of
            // cdb_out are left as they were, only valid is dropped.
            for (int i = 0; i < NUM_FU; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr        <= '0;
            cdb_out.valid <= INVALID;
            grant_id      <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    tail[i] <= ptr_next(tail[i]);
                end
                if (pop[i]) begin
                    head[i] <= ptr_next(head[i]);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
            if (any_grant) begin
                cdb_out  <= grant_entry;
                grant_id <= win;
                rr_ptr   <= rr_next;
            end else begin
                cdb_out.valid <= INVALID;
                grant_id      <= '0;
            end
        end
    end

`ifdef CDB_STALL_CNT_EN
    // Counts cycles a unit offers a result that cannot be taken; survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && !fu_ready[i] && (stall_cnt[i*8 +: 8] != 8'hFF)) begin
                    stall_cnt[i*8 +: 8] <= stall_cnt[i*8 +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [3:0]               fu_valid;
    logic [3:0]               fu_ready;
    logic [4*$bits(cdb_t)-1:0] fu_result;
    cdb_t                     cdb_out;
    logic [1:0]               grant_id;
`ifdef CDB_STALL_CNT_EN
    logic [31:0]              stall_cnt;
`endif

    cdb_t res [4];
    assign fu_result = {res[3], res[2], res[1], res[0]};

    cdb_arbiter #(.NUM_FU(4), .BUF_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_result (fu_result),
        .cdb_out   (cdb_out),
        .grant_id  (grant_id)
`ifdef CDB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per unit plus a round-robin start index.
    cdb_t       mq [4][$];
    int         rr_m;
    cdb_t       exp_out;
    logic [1:0] exp_gid;
    int         sc_m [4];

    // Observation logs for directed checks.
    int         gid_log [$];
    int         rob_log [$];
    logic       seen9;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            sc_m[i] = 0;
        end
        rr_m    = 0;
        exp_out = '0;
        exp_gid = 2'd0;
    endtask

    function automatic cdb_t rand_entry();
        cdb_t e;
        e.valid     = cdb_valid_t'($urandom_range(0, 1));
        e.rd_paddr  = 7'($urandom());
        e.rd_data   = $urandom();
        e.rd_valid  = 1'($urandom());
        e.rob_addr  = 5'($urandom());
        e.br_result = 1'($urandom());
        e.rs1_data  = $urandom();
        e.rs2_data  = $urandom();
        return e;
    endfunction

    // Called at a falling edge: drives inputs, predicts the next rising edge,
    // checks, and returns at the following falling edge.
    task automatic step(input logic [3:0] v, input logic f);
        logic [3:0] exp_rdy;
        int         w;
        int         u;
        cdb_t       head_e;
        fu_valid = v;
        flush    = f;
        #1;
        for (int i = 0; i < 4; i++) exp_rdy[i] = (mq[i].size() != 2);
        chk("fu_ready", 128'(fu_ready), 128'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (v[i] && !exp_rdy[i] && sc_m[i] < 255) sc_m[i]++;
        end
        if (f) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            exp_out.valid = INVALID;
            exp_gid       = 2'd0;
            rr_m          = 0;
        end else begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                u = (rr_m + k) % 4;
                if (w < 0 && mq[u].size() > 0) w = u;
            end
            if (w >= 0) begin
                head_e       = mq[w].pop_front();
                head_e.valid = VALID;
                exp_out      = head_e;
                exp_gid      = 2'(w);
                rr_m         = (w + 1) % 4;
            end else begin
                exp_out.valid = INVALID;
                exp_gid       = 2'd0;
            end
            for (int i = 0; i < 4; i++) begin
                if (v[i] && exp_rdy[i]) mq[i].push_back(res[i]);
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_out", 128'(cdb_out), 128'(exp_out));
        chk("grant_id", 128'(grant_id), 128'(exp_gid));
`ifdef CDB_STALL_CNT_EN
        for (int i = 0; i < 4; i++)
            chk($sformatf("stall_cnt%0d", i), 128'(stall_cnt[i*8 +: 8]), 128'(sc_m[i]));
`endif
        if (cdb_out.valid == VALID) begin
            gid_log.push_back(int'(grant_id));
            rob_log.push_back(int'(cdb_out.rob_addr));
            if (cdb_out.rob_addr == 5'd9) seen9 = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        fu_valid = 4'b0;
        for (int i = 0; i < 4; i++) res[i] = '0;
        seen9 = 1'b0;
        model_reset();

        // Reset state
        #1;
        chk("rst_cdb_out", 128'(cdb_out), 128'(0));
        chk("rst_grant", 128'(grant_id), 128'(0));
        chk("rst_ready", 128'(fu_ready), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 128'(fu_ready), 128'(4'hF));
        @(negedge clk);

        // Single result from ARITH
        res[ARITH_UNIT].rob_addr = 5'd5;
        res[ARITH_UNIT].rd_paddr = 7'd7;
        res[ARITH_UNIT].rd_data  = 32'hDEADBEEF;
        step(4'b0001, 1'b0);
        chk("single_not_yet", 128'(cdb_out.valid), 128'(0));
        step(4'b0000, 1'b0);
        chk("single_valid", 128'(cdb_out.valid), 128'(1));
        chk("single_rob", 128'(cdb_out.rob_addr), 128'(5));
        chk("single_paddr", 128'(cdb_out.rd_paddr), 128'(7));
        chk("single_data", 128'(cdb_out.rd_data), 128'(32'hDEADBEEF));
        chk("single_gid", 128'(grant_id), 128'(0));
        step(4'b0000, 1'b0);
        chk("single_gone", 128'(cdb_out.valid), 128'(0));

        // Round-robin: two back-to-back batches from all units
        step(4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) res[i].rob_addr = 5'(i);
        step(4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) res[i].rob_addr = 5'(i + 4);
        gid_log.delete();
        rob_log.delete();
        step(4'b1111, 1'b0);
        for (int k = 0; k < 7; k++) step(4'b0000, 1'b0);
        chk("rr_count", 128'(rob_log.size()), 128'(8));
        for (int k = 0; k < 8 && k < rob_log.size(); k++) begin
            chk($sformatf("rr_gid%0d", k), 128'(gid_log[k]), 128'(k % 4));
            chk($sformatf("rr_rob%0d", k), 128'(rob_log[k]), 128'(k));
        end

        // Backpressure: MUL_DIV for 5 cycles against a streaming ARITH
        gid_log.delete();
        rob_log.delete();
        for (int c = 0; c < 5; c++) begin
            res[ARITH_UNIT].rob_addr   = 5'(16 + c);
            res[MUL_DIV_UNIT].rob_addr = 5'(24 + c);
            step(4'b1001, 1'b0);
        end
        for (int c = 0; c < 3; c++) begin
            res[ARITH_UNIT].rob_addr = 5'(21 + c);
            step(4'b0001, 1'b0);
        end
        for (int c = 0; c < 5; c++) step(4'b0000, 1'b0);
        chk("bp_total", 128'(gid_log.size()), 128'(8));
        if (gid_log.size() >= 6) begin
            chk("bp_md1", 128'(gid_log[1]), 128'(3));
            chk("bp_md3", 128'(gid_log[3]), 128'(3));
            chk("bp_md5", 128'(gid_log[5]), 128'(3));
        end
`ifdef CDB_STALL_CNT_EN
        chk("bp_stall3", 128'(stall_cnt[31:24]), 128'(2));
`endif

        // Flush with MEM and BR results buffered while ARITH offers rob 9
        res[MEM_UNIT].rob_addr = 5'd20;
        res[BR_UNIT].rob_addr  = 5'd21;
        step(4'b0110, 1'b0);
        res[MEM_UNIT].rob_addr = 5'd22;
        res[BR_UNIT].rob_addr  = 5'd23;
        step(4'b0110, 1'b0);
        res[MEM_UNIT].rob_addr = 5'd24;
        step(4'b0010, 1'b0);
        seen9 = 1'b0;
        res[ARITH_UNIT].rob_addr = 5'd9;
        step(4'b0001, 1'b1);
        chk("flush_invalid", 128'(cdb_out.valid), 128'(0));
        #1;
        chk("flush_ready", 128'(fu_ready), 128'(4'hF));
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b0);
        chk("flush_no_rob9", 128'(seen9), 128'(0));

        // BR stream of 6 wraps its buffer pointers
        rob_log.delete();
        for (int k = 0; k < 6; k++) begin
            res[BR_UNIT].rob_addr = 5'(10 + k);
            step(4'b0100, 1'b0);
        end
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b0);
        chk("wrap_count", 128'(rob_log.size()), 128'(6));
        for (int k = 0; k < 6 && k < rob_log.size(); k++)
            chk($sformatf("wrap_rob%0d", k), 128'(rob_log[k]), 128'(10 + k));

        // Asynchronous reset while a broadcast is on the bus
        res[ARITH_UNIT].rob_addr = 5'd3;
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        chk("pre_arst_valid", 128'(cdb_out.valid), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 128'(cdb_out.valid), 128'(0));
        chk("arst_ready", 128'(fu_ready), 128'(0));
        chk("arst_grant", 128'(grant_id), 128'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b0);

        // Randomised traffic with occasional flushes
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) res[i] = rand_entry();
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 24) == 0));
        end
        for (int c = 0; c < 10; c++) step(4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
